// File: rtl/excess3_pkg.sv
// Shared definitions for the excess-3 stream decoder.
// Holds the excess-3 code range, the substitute digit emitted for bad
// codes, and the frame state encoding.
package excess3_pkg;

   localparam logic [3:0] EX3_OFFSET = 4'd3;
   localparam logic [3:0] EX3_MIN    = 4'b0011;
   localparam logic [3:0] EX3_MAX    = 4'b1100;
   localparam logic [3:0] BAD_DIGIT  = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_e;

endpackage

// File: rtl/excess3_digit_dec.sv
// Combinational excess-3 to BCD digit decoder.
// Ports:
//   code_i    : excess-3 coded digit
//   digit_o   : decoded BCD digit (0..9), or BAD_DIGIT when the code is invalid
//   invalid_o : code is outside the excess-3 range
module excess3_digit_dec
   import excess3_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [3:0] digit_o,
   output logic       invalid_o
);

   always_comb begin
      invalid_o = (code_i < EX3_MIN) || (code_i > EX3_MAX);
      digit_o   = invalid_o ? BAD_DIGIT : (code_i - EX3_OFFSET);
   end

endmodule

// File: rtl/excess3_stream_decoder.sv
// Serial excess-3 digit stream to right-aligned packed-BCD frame decoder.
// Digits arrive MSD first; a frame closes on in_last or after DIGITS digits
// and is held on a valid/ready output until the consumer takes it.
// Optional feature macro: EXCESS3_BIN_EN adds out_bin, the binary value of
// the frame (invalid digits contribute 0).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input digit handshake
//   in_digit, in_last   : excess-3 digit and end-of-frame marker
//   out_valid/out_ready : frame handshake
//   out_bcd             : packed BCD, digit 0 in bits [3:0]
//   out_count           : number of digits in the frame
//   out_err             : frame contained at least one invalid code
//   out_bin             : binary frame value (EXCESS3_BIN_EN only)
//
// state   | meaning
// IDLE    | no frame in progress; first accepted digit starts a fresh frame
// COLLECT | frame partially received, waiting for more digits
// HOLD    | frame complete and presented on out_*, input stalled
module excess3_stream_decoder
   import excess3_pkg::*;
#(
   parameter  int DIGITS = 4,
   localparam int WW     = 4 * DIGITS,
   localparam int CW     = $clog2(DIGITS + 1)
`ifdef EXCESS3_BIN_EN
   ,localparam int BW    = $clog2(10 ** DIGITS)
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_digit,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WW-1:0] out_bcd,
   output logic [CW-1:0] out_count,
   output logic          out_err
`ifdef EXCESS3_BIN_EN
   ,output logic [BW-1:0] out_bin
`endif
);

   state_e        state_q;
   logic [WW-1:0] word_q,  word_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q,   err_d;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          accept;
   logic          close;
   logic [3:0]    dig;
   logic          dig_bad;

`ifdef EXCESS3_BIN_EN
   logic [BW-1:0] bin_q, bin_d;
`endif

   excess3_digit_dec u_dec (
      .code_i    (in_digit),
      .digit_o   (dig),
      .invalid_o (dig_bad)
   );

   // Next-frame values for an accepted digit. In IDLE the previous frame's
   // contents are discarded so the new frame starts from zero.
   always_comb begin
      accept  = in_valid && in_ready_q;
      word_d  = (((state_q == IDLE) ? '0 : word_q) << 4) | WW'(dig);
      count_d = ((state_q == IDLE) ? '0 : count_q) + CW'(1);
      err_d   = ((state_q == IDLE) ? 1'b0 : err_q) | dig_bad;
      close   = in_last || (count_d == CW'(DIGITS));
`ifdef EXCESS3_BIN_EN
      bin_d   = ((state_q == IDLE) ? '0 : bin_q) * BW'(10)
                + (dig_bad ? '0 : BW'(dig));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef EXCESS3_BIN_EN
         bin_q       <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, COLLECT: begin
               if (accept) begin
                  word_q  <= word_d;
                  count_q <= count_d;
                  err_q   <= err_d;
`ifdef EXCESS3_BIN_EN
                  bin_q   <= bin_d;
`endif
                  if (close) begin
                     state_q     <= HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= COLLECT;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bcd   = word_q;
   assign out_count = count_q;
   assign out_err   = err_q;
`ifdef EXCESS3_BIN_EN
   assign out_bin   = bin_q;
`endif

endmodule

// File: tb/tb_excess3_stream_decoder.sv
module tb_excess3_stream_decoder;

   localparam int DIGITS = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_digit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic [2:0]  out_count;
   logic        out_err;
`ifdef EXCESS3_BIN_EN
   logic [13:0] out_bin;
`endif

   excess3_stream_decoder #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_digit  (in_digit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .out_count (out_count),
      .out_err   (out_err)
`ifdef EXCESS3_BIN_EN
      ,.out_bin  (out_bin)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [2:0]  cnt;
      logic        err;
      logic [13:0] bin;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] bcd, input logic [2:0] cnt,
                       input logic err, input logic [13:0] bin);
      exp_t e;
      e.bcd = bcd; e.cnt = cnt; e.err = err; e.bin = bin;
      sb.push_back(e);
   endtask

   // Monitor: every frame the consumer takes is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got bcd %0h expected no frame", out_bcd);
         end else begin
            mon_e = sb.pop_front();
            chk("frame_bcd", 32'(out_bcd), 32'(mon_e.bcd));
            chk("frame_count", 32'(out_count), 32'(mon_e.cnt));
            chk("frame_err", 32'(out_err), 32'(mon_e.err));
`ifdef EXCESS3_BIN_EN
            chk("frame_bin", 32'(out_bin), 32'(mon_e.bin));
`endif
         end
      end
   end

   // Presents one digit and holds it until accepted (bounded wait).
   task automatic send(input logic [3:0] d, input logic last);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_digit = d;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic chk_latency();
      @(negedge clk);
      chk("out_valid_latency", 32'(out_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_digit  = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_bcd", 32'(out_bcd), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef EXCESS3_BIN_EN
      chk("rst_out_bin", 32'(out_bin), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1,2,3,4 closed by in_last
      push(16'h1234, 3'd4, 1'b0, 14'd1234);
      send(4'b0100, 1'b0);
      send(4'b0101, 1'b0);
      send(4'b0110, 1'b0);
      send(4'b0111, 1'b1);
      chk_latency();
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // boundary codes 0 and 9
      push(16'h0009, 3'd2, 1'b0, 14'd9);
      send(4'b0011, 1'b0);
      send(4'b1100, 1'b1);
      chk_latency();

      // invalid code in the middle
      push(16'h01F7, 3'd3, 1'b1, 14'd107);
      send(4'b0100, 1'b0);
      send(4'b0000, 1'b0);
      send(4'b1010, 1'b1);
      chk_latency();
      @(posedge clk);
      #1;

      // consumer stalls 5 cycles
      out_ready = 1'b0;
      push(16'h8765, 3'd4, 1'b0, 14'd8765);
      send(4'b1011, 1'b0);
      send(4'b1010, 1'b0);
      send(4'b1001, 1'b0);
      send(4'b1000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_bcd", 32'(out_bcd), 32'h8765);
         chk("stall_out_count", 32'(out_count), 32'd4);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // five digits, no in_last: count closes frame 1, fifth digit starts frame 2
      push(16'h1234, 3'd4, 1'b0, 14'd1234);
      push(16'h0053, 3'd2, 1'b0, 14'd53);
      send(4'b0100, 1'b0);
      send(4'b0101, 1'b0);
      send(4'b0110, 1'b0);
      send(4'b0111, 1'b0);
      in_valid = 1'b1;
      in_digit = 4'b1000;
      in_last  = 1'b0;
      @(negedge clk);
      chk("fifth_held_in_ready", 32'(in_ready), 32'd0);
      chk("count_close_out_valid", 32'(out_valid), 32'd1);
      send(4'b1000, 1'b0);
      send(4'b0110, 1'b1);
      chk_latency();
      @(posedge clk);
      #1;

      // reset mid-frame discards the partial frame
      send(4'b0100, 1'b0);
      send(4'b0101, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_bcd", 32'(out_bcd), 32'd0);
      chk("midrst_out_count", 32'(out_count), 32'd0);
      chk("midrst_out_err", 32'(out_err), 32'd0);
`ifdef EXCESS3_BIN_EN
      chk("midrst_out_bin", 32'(out_bin), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      push(16'h0033, 3'd2, 1'b0, 14'd33);
      send(4'b0110, 1'b0);
      send(4'b0110, 1'b1);
      chk_latency();

      w = 0;
      while (sb.size() != 0 && w < 20) begin
         w++;
         @(negedge clk);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending frames expected 0", sb.size());
      end
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
